eth_rx_pkt_gate: RTL
====================

# eth_rx_pkt_gate

Receive-side packet gate between the 10GbE MAC RX stream and the Ethernet/CHDR adapter's `s_mac_*` input. It buffers whole frames and releases only complete, error-free frames no longer than the MTU. Frames flagged bad by the MAC, oversized frames, and frames that do not fit in the buffer are dropped entirely. The MAC side cannot be back-pressured, so the input has no ready. Per-cause drop counters are exported for the status registers.

## Interface
- `SIZE`, 11, log2 of buffer depth in 64-bit words.
- `MTU`, 10, log2 of the maximum frame length in 64-bit words. Requires MTU ≤ SIZE.

- `clk` in 1: single clock.
- `rst` in 1: synchronous, active-high reset.
- `clear` in 1: synchronous flush, active-high.
- `s_mac_tdata` in 64: input frame data.
- `s_mac_tuser` in 4: [2:0] valid bytes in the last word (0 = 8); [3] MAC error, meaningful on tlast only.
- `s_mac_tlast` in 1: last word of the frame.
- `s_mac_tvalid` in 1: beat present; always consumed.
- `m_mac_tdata`, `m_mac_tuser`, `m_mac_tlast` out 64/4/1: output frame; tuser is passed through unchanged.
- `m_mac_tvalid` out 1; `m_mac_tready` in 1: output handshake.
- `drop_err_cnt` out 16: frames dropped because tuser[3] was set on tlast.
- `drop_size_cnt` out 16: frames dropped for exceeding 2^MTU words.
- `drop_ovf_cnt` out 16: frames dropped because the buffer was full.
- `pkt_cnt` out 16: frames committed.

## Operation
- Storage: 2^SIZE × 69-bit RAM holding {tlast, tuser, tdata}.
- Pointers are SIZE+1 bits wide:
  - `wr_ptr`: speculative write position.
  - `wr_commit`: end of the last committed frame.
  - `rd_ptr`: read position.
- Full: `wr_ptr - rd_ptr == 2^SIZE` (modulo 2^(SIZE+1)). All pointer arithmetic wraps modulo 2^(SIZE+1).
- Writer FSM has three states: BOUNDARY, ACCEPT, DISCARD. Reset state is BOUNDARY. A word counter `wcnt` (MTU+1 bits) counts words in the current frame.
- BOUNDARY / ACCEPT, on each valid beat, in this priority order:
  - Buffer full → `wr_ptr ← wr_commit`. If tlast: `drop_ovf_cnt++` and go to BOUNDARY. Otherwise go to DISCARD with cause OVF.
  - Beat would be word 2^MTU+1 → `wr_ptr ← wr_commit`. If tlast: `drop_size_cnt++` and go to BOUNDARY. Otherwise go to DISCARD with cause SIZE.
  - Otherwise write at `wr_ptr` and increment it.
  - On tlast with tuser[3]=1 → `wr_ptr ← wr_commit`, `drop_err_cnt++`.
  - On tlast with tuser[3]=0 → `wr_commit ← wr_ptr+1`, `pkt_cnt++`.
  - On any tlast, go to BOUNDARY. Otherwise go to ACCEPT.
- DISCARD: beats are ignored. On tlast, increment the latched cause's counter (if a cause is set) and go to BOUNDARY. A frame is counted exactly once, under the first cause that occurred.
- A frame of exactly 2^MTU words is accepted.
- Reader:
  - Data is available when `rd_ptr != wr_commit`.
  - A one-deep output register is backed by a one-deep skid. RAM read is synchronous.
  - `rd_ptr` advances on each RAM read.
  - Frames are never interleaved, truncated, or reordered.
- `clear`:
  - `wr_ptr`, `wr_commit`, `rd_ptr` ← 0; output and skid registers are emptied.
  - If the writer was in ACCEPT or DISCARD, go to DISCARD with no cause. The tail of that frame is not counted.
  - Counters are not affected.
- `rst` zeroes everything, including counters, and puts the writer in BOUNDARY.
- Counters wrap at 2^16.

## Timing
- Reset values: `m_mac_tvalid`=0, `m_mac_tdata`/`tuser`/`tlast`=0, all counters 0.
- Commit latency: tlast beat accepted in cycle N → `wr_commit` is updated at the end of N.
  - With an empty output path, the first word is on `m_mac_tvalid` in cycle N+2.
  - A frame is never visible before its tlast is committed (store-and-forward).
- Throughput: one word per cycle while `m_mac_tready`=1, including across frame boundaries.
- Output handshake:
  - `m_mac_tdata`/`tuser`/`tlast` are held stable while `tvalid`=1 and `tready`=0.
  - `tvalid` does not drop until the transfer completes.
- Simultaneous read and write in the same cycle are both allowed.
  - Full is evaluated against the registered `rd_ptr` (space freed this cycle is usable next cycle).
- `clear` and `rst` take effect at the end of the asserting cycle. Input beats in that same cycle are ignored.

## Test plan
- Three 8-word frames (tuser[3]=0, last tuser=3), back-to-back, `m_mac_tready`=1 → 24 words out, with each frame's first word 2 cycles after its tlast; tlast/tuser intact; `pkt_cnt`=3.
- Frame 2 of 3 ends with tuser=4'b1000 → frames 1 and 3 out unchanged; `drop_err_cnt`=1; `pkt_cnt`=2; no frame-2 words on output.
- MTU=4: frames of 16 words and 17 words → 16-word frame passes; 17-word frame dropped; `drop_size_cnt`=1; `wr_ptr` equals `wr_commit` afterwards.
- SIZE=5, `m_mac_tready`=0, 20-word frame then 20-word frame → first stored, second dropped; `drop_ovf_cnt`=1. Raising tready → exactly 20 words out.
- `clear` asserted at word 3 of a 10-word frame → that frame's tail is dropped and no counter changes; the next 4-word frame passes in full.
- Random `m_mac_tready` (50%) with 1000 random frames (1–2^MTU words, 10% with error) → scoreboard exact match on good frames; counter totals equal the generated frame counts.

Source files
------------

// File: rtl/eth_rx_pkt_gate.sv
// Store-and-forward RX gate: frames are released only once complete, error-free and within MTU.
// Latency: first word on m_mac_tvalid two cycles after the committing tlast beat (empty output path).
// Backpressure: none towards the MAC (overruns drop whole frames); output stalls on m_mac_tready via a one-deep skid.
module eth_rx_pkt_gate #(
    parameter int SIZE = 11,
    parameter int MTU  = 10
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        clear,
    input  logic [63:0] s_mac_tdata,
    input  logic [3:0]  s_mac_tuser,
    input  logic        s_mac_tlast,
    input  logic        s_mac_tvalid,
    output logic [63:0] m_mac_tdata,
    output logic [3:0]  m_mac_tuser,
    output logic        m_mac_tlast,
    output logic        m_mac_tvalid,
    input  logic        m_mac_tready,
    output logic [15:0] drop_err_cnt,
    output logic [15:0] drop_size_cnt,
    output logic [15:0] drop_ovf_cnt,
    output logic [15:0] pkt_cnt
);

    localparam int DEPTH  = 2 ** SIZE;
    localparam int FMAX   = 2 ** MTU;
    localparam int WORD_W = 69;

    typedef logic [SIZE:0]       ptr_t;
    typedef logic [MTU:0]        wcnt_t;
    typedef logic [WORD_W-1:0]   word_t;

    typedef enum logic [1:0] {
        BOUNDARY,
        ACCEPT,
        DISCARD
    } wstate_t;

    typedef enum logic [1:0] {
        CAUSE_NONE,
        CAUSE_OVF,
        CAUSE_SIZE
    } cause_t;

    localparam ptr_t  DEPTH_P = ptr_t'(DEPTH);
    localparam wcnt_t FMAX_W  = wcnt_t'(FMAX);
    localparam ptr_t  PTR_ONE = ptr_t'(1);
    localparam wcnt_t CNT_ONE = wcnt_t'(1);

    word_t mem [DEPTH];

    // ------------------------------------------------------------------
    // Writer
    // ------------------------------------------------------------------
    wstate_t wstate, wstate_nxt;
    cause_t  cause, cause_nxt;
    ptr_t    wr_ptr, wr_ptr_nxt;
    ptr_t    wr_commit, wr_commit_nxt;
    wcnt_t   wcnt, wcnt_nxt;
    ptr_t    rd_ptr;
    ptr_t    ptr_diff;
    logic    full;
    logic    mem_we;
    logic    inc_err, inc_size, inc_ovf, inc_pkt;

    // Evaluated against the registered read pointer, so space freed by a
    // read in this cycle only becomes usable in the next one.
    assign ptr_diff = wr_ptr - rd_ptr;
    assign full     = (ptr_diff == DEPTH_P);

    always_comb begin
        wstate_nxt    = wstate;
        cause_nxt     = cause;
        wr_ptr_nxt    = wr_ptr;
        wr_commit_nxt = wr_commit;
        wcnt_nxt      = wcnt;
        mem_we        = 1'b0;
        inc_err       = 1'b0;
        inc_size      = 1'b0;
        inc_ovf       = 1'b0;
        inc_pkt       = 1'b0;

        if (clear) begin
            wr_ptr_nxt    = '0;
            wr_commit_nxt = '0;
            wcnt_nxt      = '0;
            cause_nxt     = CAUSE_NONE;
            // A frame cut by the flush has its remaining beats swallowed uncounted.
            wstate_nxt    = (wstate == BOUNDARY) ? BOUNDARY : DISCARD;
        end else if (s_mac_tvalid) begin
            case (wstate)
                BOUNDARY, ACCEPT: begin
                    if (full || (wcnt == FMAX_W)) begin
                        wr_ptr_nxt = wr_commit;
                        wcnt_nxt   = '0;
                        if (s_mac_tlast) begin
                            wstate_nxt = BOUNDARY;
                            inc_ovf    = full;
                            inc_size   = !full;
                        end else begin
                            wstate_nxt = DISCARD;
                            cause_nxt  = full ? CAUSE_OVF : CAUSE_SIZE;
                        end
                    end else begin
                        mem_we     = 1'b1;
                        wr_ptr_nxt = wr_ptr + PTR_ONE;
                        wcnt_nxt   = wcnt + CNT_ONE;
                        if (s_mac_tlast) begin
                            wstate_nxt = BOUNDARY;
                            wcnt_nxt   = '0;
                            if (s_mac_tuser[3]) begin
                                wr_ptr_nxt = wr_commit;
                                inc_err    = 1'b1;
                            end else begin
                                wr_commit_nxt = wr_ptr + PTR_ONE;
                                inc_pkt       = 1'b1;
                            end
                        end else begin
                            wstate_nxt = ACCEPT;
                        end
                    end
                end
                DISCARD: begin
                    if (s_mac_tlast) begin
                        inc_ovf    = (cause == CAUSE_OVF);
                        inc_size   = (cause == CAUSE_SIZE);
                        cause_nxt  = CAUSE_NONE;
                        wstate_nxt = BOUNDARY;
                        wcnt_nxt   = '0;
                    end
                end
                default: begin
                    wstate_nxt = BOUNDARY;
                    cause_nxt  = CAUSE_NONE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wstate    <= BOUNDARY;
            cause     <= CAUSE_NONE;
            wr_ptr    <= '0;
            wr_commit <= '0;
            wcnt      <= '0;
        end else begin
            wstate    <= wstate_nxt;
            cause     <= cause_nxt;
            wr_ptr    <= wr_ptr_nxt;
            wr_commit <= wr_commit_nxt;
            wcnt      <= wcnt_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            drop_err_cnt  <= '0;
            drop_size_cnt <= '0;
            drop_ovf_cnt  <= '0;
            pkt_cnt       <= '0;
        end else begin
            if (inc_err)  drop_err_cnt  <= drop_err_cnt + 16'd1;
            if (inc_size) drop_size_cnt <= drop_size_cnt + 16'd1;
            if (inc_ovf)  drop_ovf_cnt  <= drop_ovf_cnt + 16'd1;
            if (inc_pkt)  pkt_cnt       <= pkt_cnt + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we && !rst) begin
            mem[wr_ptr[SIZE-1:0]] <= {s_mac_tlast, s_mac_tuser, s_mac_tdata};
        end
    end

    // ------------------------------------------------------------------
    // Reader: the RAM read register doubles as the output register; the
    // skid catches the presented word when a new read lands during a stall,
    // so the read enable never depends combinationally on m_mac_tready.
    // ------------------------------------------------------------------
    word_t ram_q;
    word_t skid_q;
    word_t out_word;
    logic  q_vld;
    logic  skid_vld;
    logic  avail;
    logic  rd_en;

    assign avail = (rd_ptr != wr_commit);
    assign rd_en = avail && !skid_vld && !clear;

    always_ff @(posedge clk) begin
        if (rd_en) begin
            ram_q <= mem[rd_ptr[SIZE-1:0]];
        end
    end

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            rd_ptr   <= '0;
            q_vld    <= 1'b0;
            skid_vld <= 1'b0;
            skid_q   <= '0;
        end else begin
            if (rd_en) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            if (skid_vld) begin
                if (m_mac_tready) begin
                    skid_vld <= 1'b0;
                end
            end else if (rd_en) begin
                q_vld <= 1'b1;
                if (q_vld && !m_mac_tready) begin
                    skid_vld <= 1'b1;
                    skid_q   <= ram_q;
                end
            end else if (m_mac_tready) begin
                q_vld <= 1'b0;
            end
        end
    end

    always_comb begin
        out_word = '0;
        if (skid_vld) begin
            out_word = skid_q;
        end else if (q_vld) begin
            out_word = ram_q;
        end
    end

    assign m_mac_tvalid = skid_vld || q_vld;
    assign {m_mac_tlast, m_mac_tuser, m_mac_tdata} = out_word;

endmodule
